// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR filter, one multiply-accumulate per cycle.
//   One TAPS-deep delay line per channel; one coefficient set shared by all
//   channels. A sample accepted in IDLE is shifted into its channel's line.
//   MAC then spends TAPS cycles accumulating coeff[k]*delay[ch][k], and OUT
//   presents the scaled result until it is consumed.
// Ports:
//   clk, rst                   - clock; synchronous active-high reset
//   coeff_we/addr/data         - coefficient write port, usable in any state
//   in_valid/ready/chan/data   - sample input handshake
//   out_valid/ready/chan/data  - result output handshake
// Optional feature: define FIR_TDM_ROUND_EN to round half-up before the
// result is truncated or saturated. Without it the result is truncated.
module fir_tdm #(
  parameter int WIDTH    = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coeff_we,
  input  logic [TW-1:0]    coeff_addr,
  input  logic [WIDTH-1:0] coeff_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_chan,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = PW + TW;
  localparam int HW   = ACCW + 1 - WIDTH;

`ifdef FIR_TDM_ROUND_EN
  localparam logic [ACCW:0] RND = (ACCW + 1)'(1) << (WIDTH - 1);
`else
  localparam logic [ACCW:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] coeff_q [TAPS];
  logic [WIDTH-1:0] delay_q [CHANNELS][TAPS];
  logic [ACCW-1:0]  acc_q;
  logic [TW-1:0]    tap_q;
  logic [CW-1:0]    chan_q;
  logic [CW-1:0]    out_chan_q;
  logic [WIDTH-1:0] out_data_q;

  logic             chan_ok;
  logic             last_tap;
  logic [PW-1:0]    prod;
  logic [ACCW-1:0]  acc_next;
  logic [ACCW:0]    sum_r;
  logic [HW-1:0]    sum_hi;
  logic [WIDTH-1:0] result;

  assign chan_ok   = 32'(in_chan) < CHANNELS;
  assign last_tap  = (tap_q == TW'(TAPS - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;

  // The result register is loaded on the final MAC edge straight from
  // acc + last product, so no extra pipeline cycle is spent before OUT.
  always_comb begin
    prod     = PW'(coeff_q[tap_q]) * PW'(delay_q[chan_q][tap_q]);
    acc_next = acc_q + ACCW'(prod);
    sum_r    = {1'b0, acc_next} + RND;
    sum_hi   = HW'(sum_r >> WIDTH);
    result   = (|sum_hi[HW-1:WIDTH]) ? '1 : sum_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && chan_ok) state_d = MAC;
      MAC:     if (last_tap)            state_d = OUT;
      OUT:     if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        coeff_q[k] <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) delay_q[c][k] <= '0;
      end
      acc_q      <= '0;
      tap_q      <= '0;
      chan_q     <= '0;
      out_chan_q <= '0;
      out_data_q <= '0;
    end else begin
      if (coeff_we) coeff_q[coeff_addr] <= coeff_data;
      case (state_q)
        IDLE: begin
          if (in_valid && chan_ok) begin
            for (int unsigned k = TAPS - 1; k > 0; k--)
              delay_q[in_chan][k] <= delay_q[in_chan][k-1];
            delay_q[in_chan][0] <= in_data;
            chan_q <= in_chan;
            acc_q  <= '0;
            tap_q  <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_next;
          tap_q <= tap_q + 1'b1;
          if (last_tap) begin
            out_data_q <= result;
            out_chan_q <= chan_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: randomized and directed bench for fir_tdm against an
// arithmetic reference model (per-channel sample history + coefficient array).
// CHANNELS=3 so that an out-of-range channel (3) is encodable on in_chan.
module tb_fir_tdm;

  localparam int W  = 8;
  localparam int T  = 4;
  localparam int CH = 3;

  logic         clk = 0;
  logic         rst = 1;
  logic         coeff_we = 0;
  logic [1:0]   coeff_addr = '0;
  logic [W-1:0] coeff_data = '0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [1:0]   in_chan = '0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [1:0]   out_chan;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  int cf [T];
  int hist [CH][T];

  fir_tdm #(.WIDTH(W), .TAPS(T), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_out(input int ch);
    longint s = 0;
    for (int k = 0; k < T; k++) s += longint'(cf[k]) * longint'(hist[ch][k]);
`ifdef FIR_TDM_ROUND_EN
    s += 128;
`endif
    s = s / 256;
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < T; k++) begin
      cf[k] = 0;
      for (int c = 0; c < CH; c++) hist[c][k] = 0;
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic wr_coeff(input int a, input int d);
    coeff_we = 1; coeff_addr = 2'(a); coeff_data = W'(d);
    @(posedge clk); #1;
    coeff_we = 0;
    cf[a] = d;
  endtask

  task automatic send(input int ch, input int d);
    bit rdy;
    bit done = 0;
    in_chan = 2'(ch); in_data = W'(d); in_valid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    in_valid = 0;
    if (!done) check("accept_timeout", 0, 1);
    else if (ch < CH) begin
      for (int k = T - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = d;
    end
  endtask

  // Waits for a result; optionally holds out_ready low for 'stall' cycles
  // while checking that the presented result does not move.
  task automatic recv(input int stall, output int c, output int dt,
                      output int lat, output bit ok);
    ok = 0; lat = 0; c = 0; dt = 0;
    out_ready = (stall == 0);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); lat++;
      if (out_valid) begin ok = 1; c = int'(out_chan); dt = int'(out_data); end
    end
    if (!ok) begin
      check("result_timeout", 0, 1);
      out_ready = 1;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, dt);
      check("stall_chan", out_chan, c);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
  endtask

  // One sample through the filter; returns the DUT's output value.
  task automatic xact(input int ch, input int d, input int stall, output int got);
    int c, lat, exp, hi;
    bit ok;
    got = -1;
    send(ch, d);
    if (ch >= CH) begin
      hi = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); hi += int'(out_valid); end
      check("invalid_no_output", hi, 0);
      check("invalid_in_ready", in_ready, 1);
      @(posedge clk); #1;
      return;
    end
    exp = model_out(ch);
    recv(stall, c, got, lat, ok);
    if (!ok) return;
    check("latency", lat, 5);
    check("out_chan", c, ch);
    check("out_data", got, exp);
  endtask

  int got;
  int imp [4];
  int st;

  initial begin
`ifdef FIR_TDM_ROUND_EN
    imp = '{16, 32, 64, 128};
`else
    imp = '{15, 31, 63, 127};
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    @(posedge clk); #1;

    // impulse on ch0
    wr_coeff(0, 16); wr_coeff(1, 32); wr_coeff(2, 64); wr_coeff(3, 128);
    for (int i = 0; i < 4; i++) begin
      xact(0, (i == 0) ? 255 : 0, 0, got);
      check("impulse_const", got, imp[i]);
    end

    // channel isolation
    xact(0, 255, 0, got); check("iso_ch0_a", got, imp[0]);
    xact(1, 0, 0, got);   check("iso_ch1", got, 0);
    xact(0, 0, 0, got);   check("iso_ch0_b", got, imp[1]);

    // flush ch0, discard an invalid-channel sample, then repeat the impulse
    for (int i = 0; i < 4; i++) xact(0, 0, 0, got);
    xact(3, 200, 0, got);
    for (int i = 0; i < 4; i++) begin
      xact(0, (i == 0) ? 255 : 0, 0, got);
      check("post_invalid_impulse", got, imp[i]);
    end

    // backpressure: result held 10 cycles with out_ready low
    xact(2, 173, 10, got);

    // saturation
    for (int k = 0; k < 4; k++) wr_coeff(k, 255);
    for (int i = 0; i < 4; i++) xact(0, 255, 0, got);
    check("saturate_const", got, 255);

    // reset in the middle of MAC
    send(0, 255);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    @(negedge clk);
    check("midmac_in_ready", in_ready, 1);
    check("midmac_out_valid", out_valid, 0);
    check("midmac_out_data", out_data, 0);
    @(posedge clk); #1;
    xact(0, 255, 0, got);
    check("midmac_coeffs_cleared", got, 0);

    // randomized traffic with occasional coefficient updates and stalls
    for (int k = 0; k < 4; k++) wr_coeff(k, int'($urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        wr_coeff(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      xact(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), st, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
